// File: rtl/cva6v_ariane_pkg.sv
// Shared CVA6V retire/trace types: RVFI retire record and the compact trace record
// captured by the trace sink, plus the mapping between them.
package cva6v_ariane_pkg;

  localparam int unsigned RvfiXlen = 64;
  localparam int unsigned OrderW   = 64;

  typedef struct packed {
    logic                valid;
    logic [OrderW-1:0]   order;
    logic [31:0]         insn;
    logic                trap;
    logic                halt;
    logic                intr;
    logic [RvfiXlen-1:0] cause;
    logic [1:0]          mode;
    logic [1:0]          ixl;
    logic [4:0]          rs1_addr;
    logic [4:0]          rs2_addr;
    logic [RvfiXlen-1:0] rs1_rdata;
    logic [RvfiXlen-1:0] rs2_rdata;
    logic [4:0]          rd_addr;
    logic [RvfiXlen-1:0] rd_wdata;
    logic [RvfiXlen-1:0] pc_rdata;
    logic [RvfiXlen-1:0] pc_wdata;
  } rvfi_instr_t;

  typedef struct packed {
    logic [RvfiXlen-1:0] pc;
    logic [31:0]         insn;
    logic                trap;
    logic [RvfiXlen-1:0] cause;
    logic [1:0]          mode;
    logic [4:0]          rd_addr;
    logic [RvfiXlen-1:0] rd_wdata;
  } trace_rec_t;

  // FIFO entry: record plus its retirement sequence number
  typedef struct packed {
    trace_rec_t        rec;
    logic [OrderW-1:0] order;
  } trace_entry_t;

  function automatic trace_rec_t trace_rec_from_rvfi(input rvfi_instr_t r);
    trace_rec_t t;
    t.pc       = r.pc_rdata;
    t.insn     = r.insn;
    t.trap     = r.trap;
    t.cause    = r.cause;
    t.mode     = r.mode;
    t.rd_addr  = r.rd_addr;
    t.rd_wdata = r.rd_wdata;
    return t;
  endfunction

endpackage

// File: rtl/cva6v_rvfi_trace_fifo.sv
// Circular record buffer: up to NrWrPorts contiguous writes per cycle, one read.
// Caller guarantees push_cnt_i never exceeds free space and pop_i only when non-empty.
module cva6v_rvfi_trace_fifo
  import cva6v_ariane_pkg::*;
#(
  parameter int unsigned NrWrPorts = 2,
  parameter int unsigned Depth     = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic [$clog2(NrWrPorts+1)-1:0]     push_cnt_i,
  input  trace_entry_t [NrWrPorts-1:0]       wdata_i,
  input  logic                               pop_i,
  output trace_entry_t                       rdata_o,
  output logic [$clog2(Depth):0]             level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(NrWrPorts+1);
  localparam int unsigned LvlW = $clog2(Depth) + 1;

  trace_entry_t          mem [Depth];
  logic [PtrW-1:0]       wptr_q;
  logic [PtrW-1:0]       rptr_q;

  // Storage is not reset; level gates visibility of stale entries
  always_ff @(posedge clk_i) begin
    if (!flush_i && !rst_i) begin
      for (int k = 0; k < NrWrPorts; k++) begin
        if (CntW'(k) < push_cnt_i) begin
          mem[wptr_q + PtrW'(k)] <= wdata_i[k];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_o <= '0;
    end else begin
      wptr_q  <= wptr_q + PtrW'(push_cnt_i);
      rptr_q  <= rptr_q + PtrW'(pop_i);
      level_o <= level_o + LvlW'(push_cnt_i) - LvlW'(pop_i);
    end
  end

  assign rdata_o = mem[rptr_q];

endmodule

// File: rtl/cva6v_rvfi_trace_sink.sv
// RVFI trace sink: compacts multi-port retire groups into an ordered record FIFO,
// dropping whole groups that do not fit and tracking dropped-record statistics.
module cva6v_rvfi_trace_sink
  import cva6v_ariane_pkg::*;
#(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned Depth         = 8,
  parameter int unsigned XLEN          = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NrCommitPorts-1:0]       retire_valid_i,
  input  trace_rec_t [NrCommitPorts-1:0] retire_rec_i,
  input  logic                           flush_i,
  input  logic                           clr_ovf_i,
  output logic                           trace_valid_o,
  input  logic                           trace_ready_i,
  output trace_rec_t                     trace_rec_o,
  output logic [63:0]                    trace_order_o,
  output logic [$clog2(Depth):0]         level_o,
  output logic                           overflow_o,
  output logic [15:0]                    drop_cnt_o
);

  localparam int unsigned CntW = $clog2(NrCommitPorts+1);
  localparam int unsigned LvlW = $clog2(Depth) + 1;

  if (XLEN != RvfiXlen) begin : g_xlen_check
    $error("cva6v_rvfi_trace_sink: XLEN must equal cva6v_ariane_pkg::RvfiXlen");
  end

  logic [63:0]                     order_q;
  logic [CntW-1:0]                 rank [NrCommitPorts];
  logic [CntW-1:0]                 grp_cnt;
  trace_entry_t [NrCommitPorts-1:0] grp;
  logic [LvlW-1:0]                 free_slots;
  logic                            drop;
  logic [CntW-1:0]                 push_cnt;
  logic                            pop;
  logic [16:0]                     drop_sum;
  trace_entry_t                    head;

  // Rank of each valid port among the valid ports below it
  always_comb begin
    grp_cnt = '0;
    for (int i = 0; i < NrCommitPorts; i++) begin
      rank[i] = grp_cnt;
      grp_cnt = grp_cnt + CntW'(retire_valid_i[i]);
    end
  end

  always_comb begin
    grp = '0;
    for (int k = 0; k < NrCommitPorts; k++) begin
      for (int i = 0; i < NrCommitPorts; i++) begin
        if (retire_valid_i[i] && (rank[i] == CntW'(k))) begin
          grp[k].rec   = retire_rec_i[i];
          grp[k].order = order_q + 64'(k);
        end
      end
    end
  end

  // Space is judged on start-of-cycle occupancy; a concurrent pop does not help
  assign free_slots    = LvlW'(Depth) - level_o;
  assign drop          = (LvlW'(grp_cnt) > free_slots);
  assign push_cnt      = drop ? '0 : grp_cnt;
  assign trace_valid_o = (level_o != '0);
  assign pop           = trace_valid_o && trace_ready_i;
  assign drop_sum      = 17'(drop_cnt_o) + 17'(grp_cnt);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      order_q    <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      order_q <= order_q + 64'(grp_cnt);
      if (drop) begin
        overflow_o <= 1'b1;
        drop_cnt_o <= clr_ovf_i ? 16'(grp_cnt)
                                : (drop_sum[16] ? 16'hFFFF : drop_sum[15:0]);
      end else if (clr_ovf_i) begin
        overflow_o <= 1'b0;
        drop_cnt_o <= '0;
      end
    end
  end

  cva6v_rvfi_trace_fifo #(
    .NrWrPorts (NrCommitPorts),
    .Depth     (Depth)
  ) i_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .push_cnt_i (push_cnt),
    .wdata_i    (grp),
    .pop_i      (pop),
    .rdata_o    (head),
    .level_o    (level_o)
  );

  assign trace_rec_o   = head.rec;
  assign trace_order_o = head.order;

endmodule

// File: tb/tb_cva6v_rvfi_trace_sink.sv
// Directed bench for cva6v_rvfi_trace_sink (NrCommitPorts=2, Depth=8).
module tb_cva6v_rvfi_trace_sink;
  import cva6v_ariane_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       rv;
  trace_rec_t [1:0] rrec;
  logic             flush;
  logic             clr;
  logic             ready;
  logic             tv;
  trace_rec_t       trec;
  logic [63:0]      tord;
  logic [3:0]       lvl;
  logic             ovf;
  logic [15:0]      dcnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cva6v_rvfi_trace_sink #(
    .NrCommitPorts (2),
    .Depth         (8),
    .XLEN          (64)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .retire_valid_i (rv),
    .retire_rec_i   (rrec),
    .flush_i        (flush),
    .clr_ovf_i      (clr),
    .trace_valid_o  (tv),
    .trace_ready_i  (ready),
    .trace_rec_o    (trec),
    .trace_order_o  (tord),
    .level_o        (lvl),
    .overflow_o     (ovf),
    .drop_cnt_o     (dcnt)
  );

  function automatic trace_rec_t mk(input logic [63:0] pc);
    trace_rec_t r;
    r          = '0;
    r.pc       = pc;
    r.insn     = 32'h0000_0013;
    r.rd_addr  = pc[6:2];
    r.rd_wdata = pc ^ 64'hA5A5_5A5A_0F0F_F0F0;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1);
    rv      = v;
    rrec[0] = mk(pc0);
    rrec[1] = mk(pc1);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; clr = 1'b0; ready = 1'b0;
    drive(2'b00, 64'h0, 64'h0);
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tv !== 1'b0)    begin failures++; $display("FAIL reset_valid got=%0h exp=0", tv); end
    checks++; if (lvl !== 4'd0)   begin failures++; $display("FAIL reset_level got=%0d exp=0", lvl); end
    checks++; if (ovf !== 1'b0)   begin failures++; $display("FAIL reset_ovf got=%0h exp=0", ovf); end
    checks++; if (dcnt !== 16'd0) begin failures++; $display("FAIL reset_dcnt got=%0d exp=0", dcnt); end
  endtask

  task automatic test_dual_port();
    logic [63:0] exp_wd;
    do_reset();
    ready = 1'b1;
    drive(2'b11, 64'h8000_0000, 64'h8000_0004);
    cyc();
    drive(2'b00, 64'h0, 64'h0);
    checks++; if (tv !== 1'b1)              begin failures++; $display("FAIL dual_valid got=%0h exp=1", tv); end
    checks++; if (trec.pc !== 64'h8000_0000) begin failures++; $display("FAIL dual_pc0 got=%0h exp=80000000", trec.pc); end
    checks++; if (tord !== 64'd0)           begin failures++; $display("FAIL dual_ord0 got=%0d exp=0", tord); end
    checks++; if (lvl !== 4'd2)             begin failures++; $display("FAIL dual_lvl0 got=%0d exp=2", lvl); end
    cyc();
    exp_wd = 64'h8000_0004 ^ 64'hA5A5_5A5A_0F0F_F0F0;
    checks++; if (trec.pc !== 64'h8000_0004) begin failures++; $display("FAIL dual_pc1 got=%0h exp=80000004", trec.pc); end
    checks++; if (tord !== 64'd1)           begin failures++; $display("FAIL dual_ord1 got=%0d exp=1", tord); end
    checks++; if (trec.rd_wdata !== exp_wd) begin failures++; $display("FAIL dual_wdata got=%0h exp=%0h", trec.rd_wdata, exp_wd); end
    checks++; if (lvl !== 4'd1)             begin failures++; $display("FAIL dual_lvl1 got=%0d exp=1", lvl); end
    cyc();
    checks++; if (tv !== 1'b0 || lvl !== 4'd0) begin failures++; $display("FAIL dual_empty got=%0h/%0d exp=0/0", tv, lvl); end
  endtask

  task automatic test_port1_only();
    do_reset();
    ready = 1'b1;
    drive(2'b10, 64'h0, 64'h100);
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) drive(2'b00, 64'h0, 64'h0);
      checks++; if (tord !== 64'(i))     begin failures++; $display("FAIL p1_order got=%0d exp=%0d", tord, i); end
      checks++; if (trec.pc !== 64'h100) begin failures++; $display("FAIL p1_pc got=%0h exp=100", trec.pc); end
      checks++; if (lvl !== 4'd1)        begin failures++; $display("FAIL p1_level got=%0d exp=1", lvl); end
    end
    cyc();
    checks++; if (lvl !== 4'd0 || tv !== 1'b0) begin failures++; $display("FAIL p1_drain got=%0d/%0h exp=0/0", lvl, tv); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(2'b11, 64'h1000 + 64'(8*c), 64'h1004 + 64'(8*c));
      cyc();
    end
    checks++; if (lvl !== 4'd8 || ovf !== 1'b0) begin failures++; $display("FAIL ovf_full got=%0d/%0h exp=8/0", lvl, ovf); end
    drive(2'b11, 64'h2000, 64'h2004);
    cyc();
    drive(2'b00, 64'h0, 64'h0);
    checks++; if (ovf !== 1'b1)   begin failures++; $display("FAIL ovf_flag got=%0h exp=1", ovf); end
    checks++; if (dcnt !== 16'd2) begin failures++; $display("FAIL ovf_dcnt got=%0d exp=2", dcnt); end
    checks++; if (lvl !== 4'd8)   begin failures++; $display("FAIL ovf_level got=%0d exp=8", lvl); end
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (tord !== 64'(i) || trec.pc !== 64'h1000 + 64'(4*i))
        begin failures++; $display("FAIL ovf_drain i=%0d got=%0d/%0h exp=%0d/%0h", i, tord, trec.pc, i, 64'h1000 + 64'(4*i)); end
      cyc();
    end
    checks++; if (lvl !== 4'd0) begin failures++; $display("FAIL ovf_drained got=%0d exp=0", lvl); end
    drive(2'b01, 64'h3000, 64'h0);
    cyc();
    drive(2'b00, 64'h0, 64'h0);
    checks++; if (tord !== 64'd10 || trec.pc !== 64'h3000) begin failures++; $display("FAIL ovf_next got=%0d/%0h exp=10/3000", tord, trec.pc); end
    cyc();
  endtask

  task automatic test_drop_at_seven();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(2'b11, 64'h4000 + 64'(8*c), 64'h4004 + 64'(8*c));
      cyc();
    end
    drive(2'b01, 64'h4018, 64'h0);
    cyc();
    checks++; if (lvl !== 4'd7) begin failures++; $display("FAIL d7_fill got=%0d exp=7", lvl); end
    drive(2'b11, 64'h5000, 64'h5004);
    ready = 1'b1;
    cyc();
    drive(2'b00, 64'h0, 64'h0);
    ready = 1'b0;
    checks++; if (lvl !== 4'd6)   begin failures++; $display("FAIL d7_level got=%0d exp=6", lvl); end
    checks++; if (ovf !== 1'b1)   begin failures++; $display("FAIL d7_ovf got=%0h exp=1", ovf); end
    checks++; if (dcnt !== 16'd2) begin failures++; $display("FAIL d7_dcnt got=%0d exp=2", dcnt); end
    checks++; if (tord !== 64'd1) begin failures++; $display("FAIL d7_head got=%0d exp=1", tord); end
  endtask

  // Continues from the state left by test_drop_at_seven (level 6, order counter 9)
  task automatic test_flush();
    ready = 1'b1;
    cyc();
    ready = 1'b0;
    checks++; if (lvl !== 4'd5 || tord !== 64'd2) begin failures++; $display("FAIL fl_pre got=%0d/%0d exp=5/2", lvl, tord); end
    flush = 1'b1; ready = 1'b1;
    drive(2'b11, 64'h7000, 64'h7004);
    cyc();
    flush = 1'b0; ready = 1'b0;
    drive(2'b00, 64'h0, 64'h0);
    checks++; if (lvl !== 4'd0 || tv !== 1'b0)   begin failures++; $display("FAIL fl_empty got=%0d/%0h exp=0/0", lvl, tv); end
    checks++; if (ovf !== 1'b1 || dcnt !== 16'd2) begin failures++; $display("FAIL fl_ovf_kept got=%0h/%0d exp=1/2", ovf, dcnt); end
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    checks++; if (ovf !== 1'b0 || dcnt !== 16'd0) begin failures++; $display("FAIL clr got=%0h/%0d exp=0/0", ovf, dcnt); end
    drive(2'b01, 64'h6000, 64'h0);
    cyc();
    drive(2'b00, 64'h0, 64'h0);
    checks++; if (tord !== 64'd11 || lvl !== 4'd1) begin failures++; $display("FAIL fl_order got=%0d/%0d exp=11/1", tord, lvl); end
  endtask

  task automatic test_clr_vs_drop();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(2'b11, 64'h8000 + 64'(8*c), 64'h8004 + 64'(8*c));
      cyc();
    end
    drive(2'b11, 64'h9000, 64'h9004);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    drive(2'b00, 64'h0, 64'h0);
    checks++; if (ovf !== 1'b1 || dcnt !== 16'd2) begin failures++; $display("FAIL clr_drop got=%0h/%0d exp=1/2", ovf, dcnt); end
    checks++; if (lvl !== 4'd8) begin failures++; $display("FAIL clr_drop_lvl got=%0d exp=8", lvl); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    drive(2'b11, 64'hA000, 64'hA004);
    cyc();
    drive(2'b01, 64'hA008, 64'h0);
    cyc();
    checks++; if (lvl !== 4'd3) begin failures++; $display("FAIL rm_fill got=%0d exp=3", lvl); end
    rst = 1'b1; ready = 1'b1;
    drive(2'b11, 64'hB000, 64'hB004);
    cyc();
    rst = 1'b0; ready = 1'b0;
    checks++; if (tv !== 1'b0 || lvl !== 4'd0) begin failures++; $display("FAIL rm_cleared got=%0h/%0d exp=0/0", tv, lvl); end
    drive(2'b10, 64'h0, 64'h200);
    cyc();
    drive(2'b00, 64'h0, 64'h0);
    checks++; if (tord !== 64'd0 || trec.pc !== 64'h200) begin failures++; $display("FAIL rm_first got=%0d/%0h exp=0/200", tord, trec.pc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; clr = 1'b0; ready = 1'b0;
    drive(2'b00, 64'h0, 64'h0);
    test_reset();
    test_dual_port();
    test_port1_only();
    test_overflow();
    test_drop_at_seven();
    test_flush();
    test_clr_vs_drop();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cva6v_rvfi_trace_sink.md
CVA6V_RVFI_TRACE_SINK -- requirements
Module: cva6v_rvfi_trace_sink

Interface
REQ-001 SHALL have parameter NrCommitPorts, default 2, number of retire ports presented per cycle (1..4).
REQ-002 SHALL have parameter Depth, default 8, record FIFO entries (power of 2, >= 2*NrCommitPorts).
REQ-003 SHALL have parameter XLEN, default 64, architectural data/PC width.
REQ-004 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port retire_valid_i, input, NrCommitPorts, per-port retire strobe from the RVFI producer.
REQ-007 SHALL have port retire_rec_i, input, NrCommitPorts x trace_rec_t, per-port record (pc, insn[31:0], trap, cause, mode[1:0], rd_addr[4:0], rd_wdata).
REQ-008 SHALL have port flush_i, input, 1, discard all buffered records.
REQ-009 SHALL have port clr_ovf_i, input, 1, clear overflow status and drop counter.
REQ-010 SHALL have port trace_valid_o, output, 1, head record available.
REQ-011 SHALL have port trace_ready_i, input, 1, consumer accepts head record.
REQ-012 SHALL have port trace_rec_o, output, trace_rec_t, head record.
REQ-013 SHALL have port trace_order_o, output, 64, retirement sequence number of head record.
REQ-014 SHALL have port level_o, output, $clog2(Depth)+1, current FIFO occupancy.
REQ-015 SHALL have port overflow_o, output, 1, sticky "records were dropped".
REQ-016 SHALL have port drop_cnt_o, output, 16, number of dropped records, saturating at 16'hFFFF.

Function
REQ-017 Valid ports SHALL be compacted in ascending port index and enqueued in that order in one cycle; port i precedes port j>i.
REQ-018 Free space SHALL be computed as Depth - level at cycle start; a same-cycle pop SHALL NOT add space.
REQ-019 If popcount(retire_valid_i) > free space, the cycle's entire group SHALL be dropped (no partial enqueue), overflow_o set, and drop_cnt_o increased by the popcount (saturating).
REQ-020 A 64-bit order counter SHALL advance by popcount(retire_valid_i) every cycle, including dropped groups; each enqueued record stores order = counter + compacted index.
REQ-021 A pop SHALL occur when trace_valid_o && trace_ready_i; trace_valid_o = (level != 0).
REQ-022 trace_rec_o/trace_order_o SHALL be driven from the head entry with no combinational path from retire_*_i; a record accepted at edge t SHALL be visible no earlier than the cycle after edge t.
REQ-023 Simultaneous push and pop SHALL both take effect: level_next = level + pushed - popped.
REQ-024 Read and write pointers SHALL wrap modulo Depth; full is level == Depth, empty is level == 0.
REQ-025 trace_rec_o and trace_order_o SHALL hold stable while trace_valid_o && !trace_ready_i.
REQ-026 flush_i SHALL empty the FIFO (level 0, pointers equal) and take priority over same-cycle push and pop; the order counter still advances per REQ-020; overflow state is unchanged.
REQ-027 clr_ovf_i SHALL zero overflow_o and drop_cnt_o; a same-cycle drop SHALL win (overflow_o=1, drop_cnt_o=popcount).

Reset
REQ-028 On rst_i high at a clock edge: level 0, pointers 0, order counter 0, overflow_o 0, drop_cnt_o 0, trace_valid_o 0.
REQ-029 Reset SHALL override flush_i, clr_ovf_i and all traffic; FIFO storage data need not be reset.
REQ-030 Reset asserted mid-stream SHALL discard buffered records; first record after reset SHALL carry order 0.

Structure
REQ-031 trace_rec_t and a trace_rec_from_rvfi() mapping function SHALL live in cva6v_ariane_pkg next to the RVFI types.
REQ-032 Storage SHALL be one sub-module, cva6v_rvfi_trace_fifo (multi-write-port, single-read circular buffer); compaction, order and overflow logic stay in the top.

Verification
REQ-033 Reset, then port0 pc=0x8000_0000 and port1 pc=0x8000_0004 valid in one cycle, ready=1 -> outputs pc 0x8000_0000 order 0, then 0x8000_0004 order 1, on consecutive cycles.
REQ-034 Only port1 valid (pc=0x100), three cycles -> three records, orders 0,1,2, no gaps, level returns to 0.
REQ-035 ready=0, Depth=8, four cycles both ports valid -> level 8; fifth cycle both valid -> overflow_o=1, drop_cnt_o=2, level 8; after draining, orders 0..7, next enqueue order 10.
REQ-036 level=7, both ports valid with ready=1 -> group dropped (REQ-018), drop_cnt_o +2, one pop, level 6.
REQ-037 level=5, flush_i with push of 2 and pop -> level 0 next cycle; overflow_o unchanged; clr_ovf_i with no drop -> overflow_o=0, drop_cnt_o=0.
REQ-038 rst_i asserted with level=3 -> next cycle trace_valid_o=0; first post-reset record carries order 0.
